mult_div_seq: RTL and testbench

//  Sequential signed multiply/divide unit producing the HI/LO result pair consumed by the mult/div

---
 rtl/mult_div_seq.sv | 134 +++++++++++++
 tb/tb_mult_div_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide unit (shift-add multiply, restoring divide), one bit per cycle.
// Define MULTDIV_UNSIGNED_EN to add the op_unsigned port for multu/divu operation.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
`ifdef MULTDIV_UNSIGNED_EN
  ,
  input  logic             op_unsigned
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mb;
  logic             is_div, dz, neg_q, neg_r;
  logic             signed_op, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, step_hi, step_lo, q_res, r_res;
  logic [2*WIDTH-1:0] product, prod_res;

`ifdef MULTDIV_UNSIGNED_EN
  assign signed_op = !op_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  assign accept = (state == S_IDLE) && start;
  assign mag_a  = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (signed_op && b[WIDTH-1]) ? -b : b;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Both the iterative states and the div-by-zero path pass through S_FIX,
  // which applies the sign correction and writes hi/lo on the way into S_DONE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = !op ? S_MULT : ((b == '0) ? S_FIX : S_DIV);
      S_MULT,
      S_DIV:  if (cnt == '0) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Shared single-bit step; remainder stays below mb so div_sub needs only WIDTH bits.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mb});
    div_sub   = div_shift[WIDTH-1:0] - mb;
    if (state == S_DIV) begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    product  = {acc_hi, acc_lo};
    prod_res = neg_q ? -product : product;
    q_res    = neg_q ? -acc_lo : acc_lo;
    r_res    = neg_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mb       <= '0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt      <= CW'(WIDTH - 1);
          acc_hi   <= '0;
          acc_lo   <= mag_a;
          mb       <= mag_b;
          is_div   <= op;
          dz       <= op && (b == '0);
          neg_q    <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r    <= signed_op && a[WIDTH-1];
          div_zero <= 1'b0;
        end
        S_MULT, S_DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (dz) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= r_res;
            lo <= q_res;
          end else begin
            {hi, lo} <= prod_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: directed cases plus randomized operations against an arithmetic model.
module tb_mult_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op, op_unsigned;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           t0;
    int           lat;
  } exp_t;

  exp_t         expq[$];
  exp_t         mon_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
`ifdef MULTDIV_UNSIGNED_EN
    , .op_unsigned(op_unsigned)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 want=0");
      end else begin
        mon_e = expq.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
        chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
    end
  end

  // Called at a falling edge with the unit idle; accepted on the next rising edge.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic u);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    sa = u ? longint'({32'b0, x}) : longint'($signed(x));
    sb = u ? longint'({32'b0, y}) : longint'($signed(y));
    e.dz = 1'b0;
    if (!o) begin
      if (u) p = {32'b0, x} * {32'b0, y};
      else   p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = 1'b1;
    end else if (u) begin
      e.lo = x / y;
      e.hi = x % y;
    end else begin
      p = sa / sb;
      e.lo = p[31:0];
      p = sa % sb;
      e.hi = p[31:0];
    end
    m_hi  = e.hi;
    m_lo  = e.lo;
    e.t0  = cyc;
    e.lat = (o && y == '0) ? 2 : W + 2;
    expq.push_back(e);
    op = o; a = x; b = y; op_unsigned = u;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom); a = $urandom; b = $urandom; op_unsigned = 1'($urandom);
  endtask

  task automatic wait_idle(input bit inject);
    int n = 0;
    while (busy && n < 200) begin
      if (inject && $urandom_range(3) == 0) begin
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout busy=%b want=0", busy);
    end
  endtask

  initial begin
    int          n;
    logic        o, u;
    logic [W-1:0] x, y;

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; op_unsigned = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle(1'b0);
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(1'b1);
    issue(1'b1, 32'd5, 32'd0, 1'b0);
    wait_idle(1'b0);

    // Abort: a restart while busy is ignored, then reset clears everything mid-operation.
    issue(1'b0, 32'd3, 32'd4, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    expq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_abort_busy", 64'(busy), 64'd0);
    issue(1'b0, 32'd3, 32'd4, 1'b0);
    wait_idle(1'b0);

    // Back-to-back: next start raised during the done cycle and held into idle.
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout done=%b want=1", done);
    end
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'hFFFFFFFD;
    @(negedge clk);
    issue(1'b0, 32'd2, 32'hFFFFFFFD, 1'b0);
    wait_idle(1'b0);

`ifdef MULTDIV_UNSIGNED_EN
    issue(1'b0, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_idle(1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'h10, 1'b1);
    wait_idle(1'b1);
`endif

    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(7))
        0: y = '0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        3: begin x = 32'($urandom_range(20)); y = 32'($urandom_range(9)); end
        4: begin x = 32'h80000000; y = 32'h80000000; end
        default: ;
      endcase
`ifdef MULTDIV_UNSIGNED_EN
      u = 1'($urandom);
`else
      u = 1'b0;
`endif
      issue(o, x, y, u);
      wait_idle(1'b1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
